prv32_lsu: RTL and testbench
============================

# prv32_lsu

Load/store unit for the femtoRV32 execute→memory boundary. Consumes the ALU result as an effective address, plus store data and funct3, then runs one data-memory transaction over a request/acknowledge bus. Returns sign- or zero-extended load data to writeback. Misaligned accesses and bus timeouts are reported as exception pulses and never reach memory.

## Interface
- TIMEOUT, 255: max cycles in BUSY without mem_ack before bus error; legal range 1..65535.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective address (ALU sum)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  bus write
- mem_addr  out  32  word address, bits [1:0] = 00
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle transfer completion
- done  out  1  one-cycle pulse at completion of any request, including faulting ones
- wb_we  out  1  register write strobe, coincident with done
- wb_rd  out  5  destination register
- wb_data  out  32  extended load result
- exc_misaligned  out  1  one-cycle misalignment pulse, coincident with done
- exc_bus  out  1  one-cycle timeout pulse, coincident with done
- exc_addr  out  32  faulting effective address

## Operation
- States: IDLE, BUSY, RESP.
- `req_ready` = 1 only in IDLE. A request is accepted when `req_valid` && `req_ready`. All request fields are registered at acceptance.
- Alignment check at acceptance:
  - H/HU is misaligned if addr[0] = 1.
  - W is misaligned if addr[1:0] ≠ 00.
  - funct3 011, 110, 111 are treated as misaligned.
- Misaligned request: IDLE→RESP with no bus activity. In RESP: `exc_misaligned` = 1, `exc_addr` = addr, `wb_we` = 0.
- Aligned request: IDLE→BUSY. In BUSY, `mem_req` = 1 with stable address, wstrb and wdata.
- Store lanes:
  - B: wstrb = 0001 << addr[1:0], byte replicated on all four lanes.
  - H: wstrb = 0011 << addr[1:0], half replicated on both halves.
  - W: wstrb = 1111.
- Loads drive wstrb = 0000, mem_we = 0.
- Load extract: shift mem_rdata right by 8·addr[1:0], then apply the width and extension selected by funct3. BU/HU zero-extend; B/H sign-extend.
- BUSY with `mem_ack` = 1: capture extended data and go to RESP. `mem_req` drops the cycle after ack.
- BUSY timeout counter:
  - Resets to 0 on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT-1 without ack, go to RESP with `exc_bus` = 1 and `exc_addr` = addr.
  - A `mem_ack` arriving on that same cycle wins: normal completion, no exception.
- RESP lasts exactly one cycle:
  - `done` = 1.
  - For a successful load, `wb_we` = 1 only if rd ≠ 0.
  - Then go to IDLE.
- Stores never assert `wb_we`.
- `mem_ack` outside BUSY is ignored.

## Timing
- Reset values: state IDLE; `req_ready` = 1; `mem_req`, `mem_we`, `done`, `wb_we`, `exc_misaligned`, `exc_bus` = 0; `mem_addr`, `mem_wstrb`, `mem_wdata`, `wb_rd`, `wb_data`, `exc_addr` = 0.
- Assertion of `rst_n` mid-transaction aborts immediately: `mem_req` falls asynchronously and no `done` is issued.
- Accept at cycle 0:
  - `mem_req` is high from cycle 1.
  - Ack at cycle k ≥ 1 gives `done` at k+1.
  - Next accept is possible at k+2.
- Zero-wait memory (ack at cycle 1): `done` at cycle 2; throughput 1 access per 3 cycles.
- Misaligned request: `done` plus exception at cycle 1; next accept at cycle 2.
- Timeout: `done` plus `exc_bus` at cycle TIMEOUT+1 after accept.
- All outputs are registered; no combinational path from mem_* inputs to any output.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, ack at cycle 3 -> mem_addr 0x100, wstrb 1111, mem_wdata 0xDEADBEEF; `done` at cycle 4; `wb_we` = 0.
- SB addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, wstrb 1000, mem_wdata 0xA5A5A5A5.
- Byte loads from addr 0x1002, rd 7, mem_rdata 0x12F0ABCD:
  - LB -> wb_data 0xFFFFFFF0, wb_rd 7, `wb_we` = 1.
  - LBU -> wb_data 0x000000F0.
  - LH at addr 0x1002 -> wb_data 0x000012F0.
- LW addr 0x1006 -> no `mem_req`; cycle 1: `done`, `exc_misaligned` = 1, exc_addr 0x1006. LW with rd = 0 and ack -> `done` = 1, `wb_we` = 0.
- TIMEOUT = 4, no ack -> `mem_req` cycles 1–4, `exc_bus` at cycle 5. Repeat with ack at cycle 4 -> normal `done`, no `exc_bus`.
- `rst_n` low in BUSY -> `mem_req` falls immediately and `req_ready` = 1; after release, a new LW completes normally.

Source files
------------

// File: rtl/prv32_lsu.sv
// Load/store unit between execute and data memory: one request/ack bus transaction per access,
// lane steering for stores, extraction and extension for loads, misalign/timeout exception pulses.
module prv32_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_bus,
    output logic [31:0] exc_addr
);

    // state | meaning
    // IDLE  | ready for a new request
    // BUSY  | bus request outstanding, waiting for ack or timeout
    // RESP  | one-cycle completion: done plus writeback or exception
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_mis_q, exc_mis_d;
    logic        exc_bus_q, exc_bus_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic        req_misaligned;
    logic [3:0]  req_wstrb;
    logic [31:0] req_lanes;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;

    always_comb begin
        req_misaligned = 1'b1;
        case (req_funct3)
            3'b000, 3'b100: req_misaligned = 1'b0;
            3'b001, 3'b101: req_misaligned = req_addr[0];
            3'b010:         req_misaligned = (req_addr[1:0] != 2'b00);
            default:        req_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        req_wstrb = 4'b1111;
        req_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_wstrb = 4'b0001 << req_addr[1:0];
                req_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_wstrb = 4'b0011 << req_addr[1:0];
                req_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                req_wstrb = 4'b1111;
                req_lanes = req_wdata;
            end
        endcase
        if (!req_we) req_wstrb = 4'b0000;
    end

    always_comb begin
        rd_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_data = {24'h0, rd_shifted[7:0]};
            3'b101:  load_data = {16'h0, rd_shifted[15:0]};
            default: load_data = rd_shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        f3_d        = f3_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_addr_d  = exc_addr_q;
        done_d      = 1'b0;
        wb_we_d     = 1'b0;
        exc_mis_d   = 1'b0;
        exc_bus_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    we_d   = req_we;
                    f3_d   = req_funct3;
                    rd_d   = req_rd;
                    if (req_misaligned) begin
                        state_d    = S_RESP;
                        done_d     = 1'b1;
                        exc_mis_d  = 1'b1;
                        exc_addr_d = req_addr;
                    end else begin
                        state_d     = S_BUSY;
                        cnt_d       = 16'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = req_wstrb;
                        mem_wdata_d = req_lanes;
                    end
                end
            end
            S_BUSY: begin
                // ack on the terminal count still completes normally
                if (mem_ack) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    wb_we_d   = !we_q && (rd_q != 5'd0);
                    wb_rd_d   = rd_q;
                    if (!we_q) wb_data_d = load_data;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    done_d     = 1'b1;
                    exc_bus_d  = 1'b1;
                    exc_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            rd_q        <= 5'd0;
            cnt_q       <= 16'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'h0;
            mem_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0;
            exc_mis_q   <= 1'b0;
            exc_bus_q   <= 1'b0;
            exc_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_mis_q   <= exc_mis_d;
            exc_bus_q   <= exc_bus_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign mem_wdata      = mem_wdata_q;
    assign done           = done_q;
    assign wb_we          = wb_we_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign exc_misaligned = exc_mis_q;
    assign exc_bus        = exc_bus_q;
    assign exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_prv32_lsu.sv
// Self-checking bench for prv32_lsu: directed vector table, randomized accesses against a
// width/alignment reference model, and an asynchronous-reset abort sequence.
module tb_prv32_lsu;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        done, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misaligned, exc_bus;
    logic [31:0] exc_addr;

    int tests = 0;
    int fails = 0;

    prv32_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_misaligned(exc_misaligned), .exc_bus(exc_bus), .exc_addr(exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          done_cyc;
        bit          req;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          mwe;
        bit          wbwe;
        logic [4:0]  rd;
        logic [31:0] wbdata;
        bit          mis;
        bit          bus;
        logic [31:0] eaddr;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          ack;
        logic [31:0] rdata;
        exp_t        e;
    } vec_t;

    typedef struct {
        int          done_cyc;
        int          done_count;
        int          req_cycles;
        logic        ready_c1;
        logic        ready_next;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        mwe;
        logic        wbwe;
        logic [4:0]  rd;
        logic [31:0] wbdata;
        logic        mis;
        logic        bus;
        logic [31:0] eaddr;
    } obs_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: access size from funct3, alignment by modulo, lanes by arithmetic.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [4:0] rd, input int ack,
                                   input logic [31:0] rdata);
        exp_t   e;
        int     size;
        int     idx;
        int     bits;
        longint v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        idx  = int'(addr % 4);
        bits = 8 * size;
        e = '{done_cyc: 0, req: 0, maddr: addr & 32'hFFFF_FFFC, strb: 4'h0, wdata: 32'h0,
              mwe: we, wbwe: 0, rd: rd, wbdata: 32'h0, mis: 0, bus: 0, eaddr: addr};
        if (size == 0 || (idx % size) != 0) begin
            e.mis      = 1;
            e.done_cyc = 1;
            return e;
        end
        e.req = 1;
        if (we) begin
            e.strb = 4'(((1 << size) - 1) << idx);
            if (size == 1)      e.wdata = {24'h0, wdata[7:0]} * 32'h0101_0101;
            else if (size == 2) e.wdata = {16'h0, wdata[15:0]} * 32'h0001_0001;
            else                e.wdata = wdata;
        end
        if (ack >= 1 && ack <= TO) begin
            e.done_cyc = ack + 1;
            e.wbwe = !we && (rd != 0);
            v = (longint'(rdata) >> (8 * idx)) & ((64'd1 << bits) - 1);
            if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
            e.wbdata = v[31:0];
        end else begin
            e.done_cyc = TO + 1;
            e.bus = 1;
        end
        return e;
    endfunction

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input int ack,
                           input logic [31:0] rdata, output obs_t o);
        o = '{done_cyc: -1, done_count: 0, req_cycles: 0, ready_c1: 1'bx, ready_next: 1'bx,
              maddr: 32'h0, strb: 4'h0, wdata: 32'h0, mwe: 1'b0, wbwe: 1'b0, rd: 5'd0,
              wbdata: 32'h0, mis: 1'b0, bus: 1'b0, eaddr: 32'h0};
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        for (int c = 1; c <= 9; c++) begin
            mem_ack   = (c == ack);
            mem_rdata = (c == ack) ? rdata : $urandom;
            if (c == 1) begin
                o.ready_c1 = req_ready;
                o.maddr = mem_addr; o.strb = mem_wstrb; o.wdata = mem_wdata; o.mwe = mem_we;
            end
            if (mem_req) o.req_cycles++;
            if (done) begin
                if (o.done_cyc < 0) begin
                    o.done_cyc = c;
                    o.wbwe = wb_we; o.rd = wb_rd; o.wbdata = wb_data;
                    o.mis = exc_misaligned; o.bus = exc_bus; o.eaddr = exc_addr;
                end
                o.done_count++;
            end
            if (o.done_cyc > 0 && c == o.done_cyc + 1) o.ready_next = req_ready;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic check_txn(input string nm, input obs_t o, input exp_t e);
        chk({nm, ".done_cyc"}, o.done_cyc, e.done_cyc);
        chk({nm, ".done_pulses"}, o.done_count, 1);
        chk({nm, ".req_cycles"}, o.req_cycles, e.req ? e.done_cyc - 1 : 0);
        chk({nm, ".ready_c1"}, {31'h0, o.ready_c1}, 32'h0);
        chk({nm, ".ready_after"}, {31'h0, o.ready_next}, 32'h1);
        if (e.req) begin
            chk({nm, ".mem_addr"}, o.maddr, e.maddr);
            chk({nm, ".mem_wstrb"}, {28'h0, o.strb}, {28'h0, e.strb});
            chk({nm, ".mem_we"}, {31'h0, o.mwe}, {31'h0, e.mwe});
            if (e.mwe) chk({nm, ".mem_wdata"}, o.wdata, e.wdata);
        end
        chk({nm, ".wb_we"}, {31'h0, o.wbwe}, {31'h0, e.wbwe});
        chk({nm, ".exc_mis"}, {31'h0, o.mis}, {31'h0, e.mis});
        chk({nm, ".exc_bus"}, {31'h0, o.bus}, {31'h0, e.bus});
        if (e.wbwe) begin
            chk({nm, ".wb_rd"}, {27'h0, o.rd}, {27'h0, e.rd});
            chk({nm, ".wb_data"}, o.wbdata, e.wbdata);
        end
        if (e.mis || e.bus) chk({nm, ".exc_addr"}, o.eaddr, e.eaddr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        obs_t o;
        exp_t e;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wdata, r_rdata;
        logic [4:0]  r_rd;
        int          r_ack;

        //            we    f3      addr          wdata          rd    ack rdata
        //            '{done req maddr strb wdata mwe wbwe rd wbdata mis bus eaddr}
        vecs[0] = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 3, 32'h0,
                    '{4, 1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1, 0, 5'd0, 32'h0, 0, 0, 32'h0}};
        vecs[1] = '{1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 5'd5, 1, 32'h0,
                    '{2, 1, 32'h0000_0200, 4'h8, 32'hA5A5_A5A5, 1, 0, 5'd0, 32'h0, 0, 0, 32'h0}};
        vecs[2] = '{1'b0, 3'b000, 32'h0000_1002, 32'h0, 5'd7, 1, 32'h12F0_ABCD,
                    '{2, 1, 32'h0000_1000, 4'h0, 32'h0, 0, 1, 5'd7, 32'hFFFF_FFF0, 0, 0, 32'h0}};
        vecs[3] = '{1'b0, 3'b100, 32'h0000_1002, 32'h0, 5'd7, 1, 32'h12F0_ABCD,
                    '{2, 1, 32'h0000_1000, 4'h0, 32'h0, 0, 1, 5'd7, 32'h0000_00F0, 0, 0, 32'h0}};
        vecs[4] = '{1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd7, 1, 32'h12F0_ABCD,
                    '{2, 1, 32'h0000_1000, 4'h0, 32'h0, 0, 1, 5'd7, 32'h0000_12F0, 0, 0, 32'h0}};
        vecs[5] = '{1'b0, 3'b010, 32'h0000_1006, 32'h0, 5'd7, 1, 32'h1111_1111,
                    '{1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 5'd0, 32'h0, 1, 0, 32'h0000_1006}};
        vecs[6] = '{1'b0, 3'b010, 32'h0000_1008, 32'h0, 5'd0, 1, 32'h2222_2222,
                    '{2, 1, 32'h0000_1008, 4'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 0, 32'h0}};
        vecs[7] = '{1'b0, 3'b010, 32'h0000_0044, 32'h0, 5'd5, 0, 32'h0,
                    '{5, 1, 32'h0000_0044, 4'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 1, 32'h0000_0044}};
        vecs[8] = '{1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd5, 4, 32'hCAFE_F00D,
                    '{5, 1, 32'h0000_0040, 4'h0, 32'h0, 0, 1, 5'd5, 32'hCAFE_F00D, 0, 0, 32'h0}};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #3;
        chk("rst.req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst.ctl", {26'h0, mem_req, mem_we, done, wb_we, exc_misaligned, exc_bus}, 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.wb_rd", {27'h0, wb_rd}, 32'h0);
        chk("rst.wb_data", wb_data, 32'h0);
        chk("rst.exc_addr", exc_addr, 32'h0);
        #9 rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                    vecs[i].ack, vecs[i].rdata, o);
            check_txn($sformatf("vec%0d", i), o, vecs[i].e);
        end

        for (int n = 0; n < 60; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom);
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rd    = 5'($urandom);
            r_ack   = $urandom_range(1, 6);
            r_rdata = $urandom;
            e = model(r_we, r_f3, r_addr, r_wdata, r_rd, r_ack, r_rdata);
            run_txn(r_we, r_f3, r_addr, r_wdata, r_rd, r_ack, r_rdata, o);
            check_txn($sformatf("rnd%0d", n), o, e);
        end

        // Reset asserted mid-BUSY must drop the request at once and never emit done.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_2000; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort.mem_req_before", {31'h0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.mem_req", {31'h0, mem_req}, 32'h0);
        chk("abort.req_ready", {31'h0, req_ready}, 32'h1);
        chk("abort.done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        chk("abort.done_hold", {31'h0, done}, 32'h0);
        #2 rst_n = 1'b1;
        e = model(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd9, 2, 32'h5566_7788);
        run_txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd9, 2, 32'h5566_7788, o);
        check_txn("after_reset", o, e);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
